// File: rtl/mux_scan_pkg.sv
// Shared types and sizing for the mux scan sequencer.
// Continuous rescanning is enabled by defining MUX_SCAN_CONTINUOUS_EN.
package mux_scan_pkg;

  localparam int NCH   = 16;
  localparam int SEL_W = 4;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/mux_scan_sched_if.sv
// Control-plane side of the scanner: start/mask request and result valid/ready handoff.
interface mux_scan_sched_if;
  import mux_scan_pkg::*;

  logic             start_pad;
  logic [NCH-1:0]   chan_mask_pad;
  logic             busy_pad;
  logic [NCH-1:0]   result_pad;
  logic             valid_pad;
  logic             ready_pad;

  modport slave (
    input  start_pad,
    input  chan_mask_pad,
    input  ready_pad,
    output busy_pad,
    output result_pad,
    output valid_pad
  );

  modport master (
    output start_pad,
    output chan_mask_pad,
    output ready_pad,
    input  busy_pad,
    input  result_pad,
    input  valid_pad
  );

endinterface

// File: rtl/mux_scan_next_chan.sv
// Priority finder: next set mask bit strictly above i_cur, or the lowest set bit
// when i_from_start is high.
module mux_scan_next_chan
  import mux_scan_pkg::*;
(
  input  logic [NCH-1:0]   i_mask,
  input  logic [SEL_W-1:0] i_cur,
  input  logic             i_from_start,
  output logic [SEL_W-1:0] o_next,
  output logic             o_found
);

  always_comb begin
    o_next  = '0;
    o_found = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (!o_found && i_mask[i] && (i_from_start || (i > int'(i_cur)))) begin
        o_found = 1'b1;
        o_next  = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/mux_scan_sched.sv
// Scans the 16:1 mux over the enabled channels, one settle interval per channel.
// Define MUX_SCAN_CONTINUOUS_EN to rescan with the latched mask after each handoff.
module mux_scan_sched
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic             clk_pad,
  input  logic             rst_n_pad,
  mux_scan_sched_if.slave  ctrl,
  input  logic             mux_out_pad,
  output logic [SEL_W-1:0] sel_pad,
  output logic             en_pad
);

  state_t           r_state, w_state_nxt;
  logic [SEL_W-1:0] r_sel, w_sel_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [NCH-1:0]   r_mask, w_mask_nxt;
  logic [NCH-1:0]   r_result, w_result_nxt;

  logic [NCH-1:0]   w_find_mask;
  logic             w_find_from_start;
  logic [SEL_W-1:0] w_find_next;
  logic             w_find_found;

  // Outside SETTLE the finder looks for the first channel of a new scan.
  assign w_find_mask       = (r_state == S_IDLE) ? ctrl.chan_mask_pad : r_mask;
  assign w_find_from_start = (r_state != S_SETTLE);

  mux_scan_next_chan u_next_chan (
    .i_mask       (w_find_mask),
    .i_cur        (r_sel),
    .i_from_start (w_find_from_start),
    .o_next       (w_find_next),
    .o_found      (w_find_found)
  );

  always_ff @(posedge clk_pad or negedge rst_n_pad) begin
    if (!rst_n_pad) begin
      r_state  <= S_IDLE;
      r_sel    <= '0;
      r_cnt    <= '0;
      r_mask   <= '0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_sel    <= w_sel_nxt;
      r_cnt    <= w_cnt_nxt;
      r_mask   <= w_mask_nxt;
      r_result <= w_result_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_sel;
    w_cnt_nxt    = r_cnt;
    w_mask_nxt   = r_mask;
    w_result_nxt = r_result;

    case (r_state)
      S_IDLE: begin
        if (ctrl.start_pad) begin
          w_mask_nxt   = ctrl.chan_mask_pad;
          w_result_nxt = '0;
          w_cnt_nxt    = '0;
          if (w_find_found) begin
            w_state_nxt = S_SETTLE;
            w_sel_nxt   = w_find_next;
          end else begin
            w_state_nxt = S_DONE;
            w_sel_nxt   = '0;
          end
        end
      end

      S_SETTLE: begin
        if (r_cnt == CNT_W'(SETTLE - 1)) begin
          w_result_nxt[r_sel] = mux_out_pad;
          w_cnt_nxt           = '0;
          if (w_find_found) begin
            w_sel_nxt = w_find_next;
          end else begin
            w_state_nxt = S_DONE;
            w_sel_nxt   = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      S_DONE: begin
        if (ctrl.ready_pad) begin
`ifdef MUX_SCAN_CONTINUOUS_EN
          w_result_nxt = '0;
          w_cnt_nxt    = '0;
          if (w_find_found) begin
            w_state_nxt = S_SETTLE;
            w_sel_nxt   = w_find_next;
          end else begin
            w_state_nxt = S_DONE;
            w_sel_nxt   = '0;
          end
`else
          w_state_nxt = S_IDLE;
`endif
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_sel_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign sel_pad         = r_sel;
  assign en_pad          = (r_state == S_SETTLE);
  assign ctrl.busy_pad   = (r_state != S_IDLE);
  assign ctrl.valid_pad  = (r_state == S_DONE);
  assign ctrl.result_pad = r_result;

endmodule

// File: tb/tb_mux_scan_sched.sv
// Directed bench for mux_scan_sched with SETTLE=2; the mux is modelled as a
// 16-bit pattern indexed by the select lines.
module tb_mux_scan_sched;

  logic        clk;
  logic        rstN;
  logic        muxOut;
  logic [3:0]  sel;
  logic        en;
  logic [15:0] muxPattern;
  int          errorCount;
  int          checkCount;
  int          enCount;

  mux_scan_sched_if ifc ();

  mux_scan_sched #(.SETTLE(2)) dut (
    .clk_pad     (clk),
    .rst_n_pad   (rstN),
    .ctrl        (ifc.slave),
    .mux_out_pad (muxOut),
    .sel_pad     (sel),
    .en_pad      (en)
  );

  assign muxOut = muxPattern[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic [15:0] mask, input logic ready);
    ifc.start_pad     = start;
    ifc.chan_mask_pad = mask;
    ifc.ready_pad     = ready;
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    errorCount = 0;
    checkCount = 0;
    rstN       = 1'b0;
    muxPattern = 16'h0000;
    applyStimulus(1'b0, 16'h0000, 1'b0);
    waitEdges(2);
    checkOutput("rst_sel",    32'(sel), 32'd0);
    checkOutput("rst_en",     32'(en), 32'd0);
    checkOutput("rst_busy",   32'(ifc.busy_pad), 32'd0);
    checkOutput("rst_valid",  32'(ifc.valid_pad), 32'd0);
    checkOutput("rst_result", 32'(ifc.result_pad), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    waitEdges(1);

`ifdef MUX_SCAN_CONTINUOUS_EN
    // Phase within each 5-edge period: 0,1 -> ch0; 2,3 -> ch15; 4 -> DONE.
    muxPattern = 16'h8001;
    applyStimulus(1'b1, 16'h8001, 1'b1);
    waitEdges(1);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("cont_sel0", 32'(sel), 32'd0);
    checkOutput("cont_busy0", 32'(ifc.busy_pad), 32'd1);
    for (int e = 1; e <= 14; e++) begin
      waitEdges(1);
      checkOutput("cont_busy", 32'(ifc.busy_pad), 32'd1);
      case (e % 5)
        0, 1: checkOutput("cont_sel_lo", 32'(sel), 32'd0);
        2, 3: checkOutput("cont_sel_hi", 32'(sel), 32'd15);
        default: begin
          checkOutput("cont_valid",  32'(ifc.valid_pad), 32'd1);
          checkOutput("cont_result", 32'(ifc.result_pad), 32'h8001);
        end
      endcase
    end
`else
    // Full scan; mask input is changed after acceptance and must be ignored.
    muxPattern = 16'hA5A5;
    applyStimulus(1'b1, 16'hFFFF, 1'b1);
    waitEdges(1);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("t1_sel0",  32'(sel), 32'd0);
    checkOutput("t1_en0",   32'(en), 32'd1);
    checkOutput("t1_busy0", 32'(ifc.busy_pad), 32'd1);
    for (int e = 1; e <= 31; e++) begin
      waitEdges(1);
      if (e % 2 == 0) checkOutput("t1_sel", 32'(sel), 32'(e / 2));
      if (e == 31) begin
        checkOutput("t1_valid_early", 32'(ifc.valid_pad), 32'd0);
        checkOutput("t1_en_last", 32'(en), 32'd1);
      end
    end
    waitEdges(1);
    checkOutput("t1_valid",  32'(ifc.valid_pad), 32'd1);
    checkOutput("t1_result", 32'(ifc.result_pad), 32'hA5A5);
    checkOutput("t1_en_off", 32'(en), 32'd0);
    checkOutput("t1_sel_off", 32'(sel), 32'd0);
    waitEdges(1);
    checkOutput("t1_idle", 32'(ifc.busy_pad), 32'd0);

    // Sparse mask, then ready held low while start is pulsed.
    muxPattern = 16'hFFFF;
    applyStimulus(1'b1, 16'h0011, 1'b0);
    waitEdges(1);
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("t2_sel0", 32'(sel), 32'd0);
    enCount = en ? 1 : 0;
    for (int e = 1; e <= 4; e++) begin
      waitEdges(1);
      if (en) enCount++;
      if (e == 2) checkOutput("t2_sel4", 32'(sel), 32'd4);
    end
    checkOutput("t2_en_cycles", 32'(enCount), 32'd4);
    checkOutput("t2_valid",  32'(ifc.valid_pad), 32'd1);
    checkOutput("t2_result", 32'(ifc.result_pad), 32'h0011);
    applyStimulus(1'b1, 16'hFFFF, 1'b1);
    applyStimulus(1'b1, 16'hFFFF, 1'b0);
    waitEdges(5);
    checkOutput("t2_hold_valid",  32'(ifc.valid_pad), 32'd1);
    checkOutput("t2_hold_result", 32'(ifc.result_pad), 32'h0011);
    checkOutput("t2_hold_en",     32'(en), 32'd0);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    waitEdges(1);
    checkOutput("t2_back_idle", 32'(ifc.busy_pad), 32'd0);
    checkOutput("t2_valid_off", 32'(ifc.valid_pad), 32'd0);
    waitEdges(1);
    checkOutput("t2_no_queue", 32'(ifc.busy_pad), 32'd0);

    // Empty mask goes straight to DONE.
    applyStimulus(1'b1, 16'h0000, 1'b0);
    waitEdges(1);
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("t3_en0", 32'(en), 32'd0);
    waitEdges(1);
    checkOutput("t3_valid",  32'(ifc.valid_pad), 32'd1);
    checkOutput("t3_result", 32'(ifc.result_pad), 32'h0000);
    checkOutput("t3_en1",    32'(en), 32'd0);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    waitEdges(1);
    checkOutput("t3_idle", 32'(ifc.busy_pad), 32'd0);

    // Asynchronous reset during channel 7.
    applyStimulus(1'b1, 16'hFFFF, 1'b0);
    waitEdges(1);
    applyStimulus(1'b0, 16'h0000, 1'b0);
    waitEdges(14);
    checkOutput("t4_sel7",    32'(sel), 32'd7);
    checkOutput("t4_partial", 32'(ifc.result_pad), 32'h007F);
    rstN = 1'b0;
    #1;
    checkOutput("t4_rst_sel",    32'(sel), 32'd0);
    checkOutput("t4_rst_en",     32'(en), 32'd0);
    checkOutput("t4_rst_busy",   32'(ifc.busy_pad), 32'd0);
    checkOutput("t4_rst_result", 32'(ifc.result_pad), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(1'b1, 16'hFFFF, 1'b1);
    waitEdges(1);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("t4_restart_sel", 32'(sel), 32'd0);
    checkOutput("t4_restart_en",  32'(en), 32'd1);
    waitEdges(31);
    checkOutput("t4_mid_valid", 32'(ifc.valid_pad), 32'd0);
    waitEdges(1);
    checkOutput("t4_valid",  32'(ifc.valid_pad), 32'd1);
    checkOutput("t4_result", 32'(ifc.result_pad), 32'hFFFF);
    waitEdges(1);
    checkOutput("t4_idle", 32'(ifc.busy_pad), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
